// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: default FIFO geometry and the FIFO
//               status-flag bundle with its derivation helper.
// Revision    : 1.0 - initial parametrised FIFO release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_FIFO_ADDR_W = 3;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Flag bundle for a given fill level; thresholds are inclusive.
  function automatic fifo_status_t fifo_status(input int lvl, input int depth,
                                               input int af, input int ae);
    fifo_status_t s;
    s.full         = (lvl == depth);
    s.empty        = (lvl == 0);
    s.almost_full  = (lvl >= af);
    s.almost_empty = (lvl <= ae);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_ctrl_if
// Description : Host/core-facing bus of the UART FIFO. The error-flag signals
//               exist only when UART_FIFO_ERR_FLAGS_EN is defined.
// Revision    : 1.0 - initial parametrised FIFO release
// ============================================================================
interface uart_fifo_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_ADDR_W
);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
`ifdef UART_FIFO_ERR_FLAGS_EN
  logic              err_clr;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );
`else
  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, level
  );
`endif

endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : Simple dual-port storage array with a write port and an
//               enable-gated registered read port. Not reset.
// Revision    : 1.0 - initial parametrised FIFO release
// ============================================================================
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic              re,
  input  wire logic [ADDR_W-1:0] raddr,
  output      logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [1 << ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Write and read share the edge; a read of the slot being written returns
  // the old word, which is what a full FIFO doing read+write needs.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata      <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_ctrl
// Description : Parametrised synchronous FIFO for the UART TX/RX datapaths.
//               Pointer, level and registered flag logic around uart_fifo_mem.
//               Optional sticky overflow/underflow flags with err_clr are
//               built when UART_FIFO_ERR_FLAGS_EN is defined.
// Revision    : 1.0 - initial parametrised FIFO release
// ============================================================================
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int ADDR_W   = UART_FIFO_ADDR_W,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input wire logic       clk,
  input wire logic       reset,
  uart_fifo_ctrl_if.slave bus
);

  localparam int              C_DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_LVL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);
  localparam fifo_status_t    C_STATUS_RST = '{full: 1'b0, empty: 1'b1,
                                               almost_full: 1'b0,
                                               almost_empty: 1'b1};

  // Threshold ordering must hold or the flags become meaningless.
  generate
    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= C_DEPTH))) begin : g_param_check
      $fatal(1, "uart_fifo_ctrl: need AE_LEVEL < AF_LEVEL <= 2**ADDR_W");
    end
  endgenerate

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  fifo_status_t      r_status;
  logic              r_rd_valid;
  logic              r_rd_seen;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [ADDR_W:0]   w_level_nxt;
  fifo_status_t      w_status_nxt;
  logic [DATA_W-1:0] w_mem_rdata;

  // A read frees a slot in the same cycle, so a full FIFO can still accept a
  // write alongside it; an empty FIFO never bypasses write data to the read.
  assign w_rd_acc = bus.rd_en & ~r_status.empty;
  assign w_wr_acc = bus.wr_en & (~r_status.full | w_rd_acc);
  assign w_mem_we = w_wr_acc & ~bus.flush;
  assign w_mem_re = w_rd_acc & ~bus.flush;

  // Next fill level; flush wins over any concurrent access.
  always_comb begin
    w_level_nxt = r_level;
    if (bus.flush) begin
      w_level_nxt = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_level_nxt = r_level + C_LVL_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_level_nxt = r_level - C_LVL_ONE;
    end
  end

  // Flags come from the next level so they line up with level itself.
  always_comb begin
    w_status_nxt = fifo_status(int'(w_level_nxt), C_DEPTH, AF_LEVEL, AE_LEVEL);
  end

  // Pointer, level, flag and read-strobe state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_status   <= C_STATUS_RST;
      r_rd_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_level    <= w_level_nxt;
      r_status   <= w_status_nxt;
      r_rd_valid <= w_mem_re;
      r_rd_seen  <= r_rd_seen | w_mem_re;
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (r_wr_ptr),
    .wdata (bus.wr_data),
    .re    (w_mem_re),
    .raddr (r_rd_ptr),
    .rdata (w_mem_rdata)
  );

  // The storage read register has no reset, so rd_data reads as zero until
  // the first word has actually been popped; afterwards it holds.
  assign bus.rd_data      = r_rd_seen ? w_mem_rdata : '0;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.level        = r_level;
  assign bus.full         = r_status.full;
  assign bus.empty        = r_status.empty;
  assign bus.almost_full  = r_status.almost_full;
  assign bus.almost_empty = r_status.almost_empty;

`ifdef UART_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (bus.wr_en & ~w_wr_acc) | (r_overflow & ~bus.err_clr);
      r_underflow <= (bus.rd_en & r_status.empty) | (r_underflow & ~bus.err_clr);
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Parametrised synchronous FIFO for the UART TX and RX datapaths.
- Generalises the earlier fixed 8-deep FIFO:
  - configurable width and depth;
  - correct simultaneous read/write;
  - level output and programmable almost-full/almost-empty flags;
  - synchronous flush and registered read data with a valid strobe.
- Sits between the UART core (rx shift register / tx serialiser) and the host-side register interface.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W (default 8).
- AF_LEVEL, 6, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pointers and level.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  registered read word.
- rd_valid  out  1  one-cycle strobe; rd_data holds a newly popped word.
- full  out  1  level == depth.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  ADDR_W+1  number of stored words.

Behaviour:
- One clock, clk. Reset is asynchronous, active-high.
- Reset values:
  - wr_ptr, rd_ptr, level = 0;
  - rd_data = 0, rd_valid = 0;
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Storage array is not reset.
- wr_acc = wr_en & (~full | rd_acc).
- rd_acc = rd_en & ~empty.
- Write: on wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read: on rd_acc, rd_data <= mem[rd_ptr], rd_ptr increments, rd_valid = 1 next cycle. rd_data holds otherwise.
- Read latency: 1 cycle from the rd_en edge to rd_data/rd_valid.
- Level update:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged on both or neither.
- Full plus simultaneous read and write: both accepted, level stays at depth, full stays 1.
- Empty plus simultaneous read and write: read rejected (no bypass), write accepted, level goes to 1, rd_valid = 0.
- Write while full without read: dropped; pointers and memory unchanged.
- Read while empty: ignored; rd_data holds.
- Pointers are ADDR_W bits and wrap modulo depth naturally. level is ADDR_W+1 bits and never exceeds depth.
- Flags are registered and computed from next-level, so they are valid in the same cycle as level.
- flush has priority over wr_en/rd_en:
  - pointers and level go to 0, empty = 1, rd_valid = 0;
  - rd_data holds its last value;
  - memory is untouched.
- Reset asserted mid-operation clears all state immediately, independent of clk. The first write is accepted on the first clock edge after reset deasserts.
- Elaboration-time check: AE_LEVEL < AF_LEVEL <= 2**ADDR_W; otherwise a fatal elaboration error.

Optional Feature:
- Macro: UART_FIFO_ERR_FLAGS_EN.
- Defined:
  - adds ports overflow (out, 1), underflow (out, 1) and err_clr (in, 1);
  - overflow sets sticky on wr_en & ~wr_acc;
  - underflow sets sticky on rd_en & empty;
  - both clear on reset or on err_clr; set has priority over err_clr in the same cycle;
  - flush does not clear them.
- Undefined: these ports and their logic are absent; drop behaviour is otherwise identical.

Decomposition:
- Shared package uart_pkg holds:
  - default UART_DATA_W = 8;
  - default UART_FIFO_ADDR_W = 3;
  - the flag-bundle typedef fifo_status_t {full, empty, almost_full, almost_empty}.
- One natural sub-module: uart_fifo_mem, a simple dual-port array with write port and registered read port. It has no reset.
- Pointer, level and flag logic stays in uart_fifo_ctrl.

Test Plan:
1. Reset, then write 0x11..0x18 (8 words) -> level steps 1..8; almost_full at level 6; full = 1 after the 8th; a 9th write (0x99) is dropped and level stays 8.
2. From full, read 8 times -> rd_data 0x11..0x18 in order, each one cycle after rd_en with rd_valid = 1; empty = 1 and almost_empty = 1 at level 2 on the way down. A 9th read leaves rd_data = 0x18 and rd_valid = 0.
3. Full, then wr_en = rd_en = 1 with wr_data = 0xAA -> rd_data = 0x11, level stays 8, full stays 1. After wrap, the 8th subsequent read returns 0xAA.
4. Empty, then wr_en = rd_en = 1 with wr_data = 0x5C -> level = 1, rd_valid = 0. The next read returns 0x5C.
5. Level 5, then flush together with wr_en -> level = 0 and empty = 1 next cycle; nothing written. Async reset pulse mid-burst -> all flags at reset values before the next clk edge.
6. With UART_FIFO_ERR_FLAGS_EN: write while full -> overflow = 1 and held; read while empty -> underflow = 1; err_clr -> both 0 next cycle.
